// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide issue/writeback controller.
package div_ctrl_pkg;

    // funct3 encodings of the divide-class M-extension ops
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic        RstEnable      = 1'b1;
    localparam logic        DivStart       = 1'b1;
    localparam logic        DivStop        = 1'b0;
    localparam logic        DivResultReady = 1'b1;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } div_state_t;

endpackage

// File: rtl/div_result_cache.sv
// Single-entry cache of the last completed divide: {op, dividend, divisor, result}.
// Only instantiated when DIV_RESULT_CACHE_EN is defined.
module div_result_cache
    import div_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      i_lookup_op,
    input  logic [XLEN-1:0] i_lookup_dividend,
    input  logic [XLEN-1:0] i_lookup_divisor,
    output logic            o_hit,
    output logic [XLEN-1:0] o_hit_result,
    input  logic            i_store,
    input  logic [2:0]      i_store_op,
    input  logic [XLEN-1:0] i_store_dividend,
    input  logic [XLEN-1:0] i_store_divisor,
    input  logic [XLEN-1:0] i_store_result
);

    logic            r_valid;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_result;

    // capture every completed divider writeback; valid bit only cleared by reset
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_valid    <= 1'b0;
            r_op       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_result   <= '0;
        end else if (i_store) begin
            r_valid    <= 1'b1;
            r_op       <= i_store_op;
            r_dividend <= i_store_dividend;
            r_divisor  <= i_store_divisor;
            r_result   <= i_store_result;
        end
    end

    assign o_hit = r_valid
                 & (r_op == i_lookup_op)
                 & (r_dividend == i_lookup_dividend)
                 & (r_divisor == i_lookup_divisor);

    assign o_hit_result = r_result;

endmodule

// File: rtl/div_ctrl.sv
// Issue/writeback controller for the M-extension divider.
// Optional build macro: DIV_RESULT_CACHE_EN (single-entry result cache that
// bypasses the divider when an op repeats the last completed one).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no op in flight; accepts a divide from ex
// ST_WAIT | op latched, start held to divider until ready pulse or flush
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid_i,
    input  logic               is_div_i,
    input  logic [2:0]         funct3_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               flush_i,
    output logic               div_start_o,
    output logic [2:0]         div_op_o,
    output logic [XLEN-1:0]    div_dividend_o,
    output logic [XLEN-1:0]    div_divisor_o,
    output logic [RADDR_W-1:0] div_waddr_o,
    input  logic               div_ready_i,
    input  logic               div_busy_i,
    input  logic [XLEN-1:0]    div_result_i,
    input  logic [RADDR_W-1:0] div_waddr_i,
    output logic               hold_o,
    output logic               wb_we_o,
    output logic [RADDR_W-1:0] wb_waddr_o,
    output logic [XLEN-1:0]    wb_wdata_o
);

    div_state_t         r_state;
    logic [2:0]         r_op;
    logic [XLEN-1:0]    r_dividend;
    logic [XLEN-1:0]    r_divisor;
    logic [RADDR_W-1:0] r_waddr;
    logic               r_wb_we;
    logic [RADDR_W-1:0] r_wb_waddr;
    logic [XLEN-1:0]    r_wb_wdata;

    logic               w_in_wait;
    logic               w_ready;
    logic               w_accept;
    logic               w_run;
    logic               w_wb_done;
    logic               w_hit;
    logic [XLEN-1:0]    w_hit_result;
    logic               w_unused_busy;

    // divider busy is status only; control relies solely on the ready pulse
    assign w_unused_busy = div_busy_i;

    assign w_in_wait = (r_state == ST_WAIT);
    assign w_ready   = (div_ready_i == DivResultReady);
    assign w_accept  = (r_state == ST_IDLE) & inst_valid_i & is_div_i & ~flush_i;

    // start drops in the ready cycle so the now-idle divider cannot relaunch,
    // and on flush so an in-flight divide is aborted
    assign w_run     = w_in_wait & ~w_ready & ~flush_i;
    assign w_wb_done = w_in_wait & w_ready & ~flush_i;

`ifdef DIV_RESULT_CACHE_EN
    div_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .clk               (clk),
        .rst               (rst),
        .i_lookup_op       (funct3_i),
        .i_lookup_dividend (rs1_data_i),
        .i_lookup_divisor  (rs2_data_i),
        .o_hit             (w_hit),
        .o_hit_result      (w_hit_result),
        .i_store           (w_wb_done),
        .i_store_op        (r_op),
        .i_store_dividend  (r_dividend),
        .i_store_divisor   (r_divisor),
        .i_store_result    (div_result_i)
    );
`else
    assign w_hit        = 1'b0;
    assign w_hit_result = '0;
`endif

    // FSM: latch the op on accept, wait for ready or flush, register the writeback
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_waddr    <= '0;
            r_wb_we    <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
        end else begin
            r_wb_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= funct3_i;
                        r_dividend <= rs1_data_i;
                        r_divisor  <= rs2_data_i;
                        r_waddr    <= rd_addr_i;
                        if (w_hit) begin
                            // repeat of the cached op: write back without the divider
                            r_wb_we    <= 1'b1;
                            r_wb_waddr <= rd_addr_i;
                            r_wb_wdata <= w_hit_result;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_ready) begin
                        r_wb_we    <= 1'b1;
                        r_wb_waddr <= div_waddr_i;
                        r_wb_wdata <= div_result_i;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign div_start_o    = w_run ? DivStart : DivStop;
    assign hold_o         = w_accept | w_run;
    assign div_op_o       = r_op;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;
    assign div_waddr_o    = r_waddr;
    assign wb_we_o        = r_wb_we;
    assign wb_waddr_o     = r_wb_waddr;
    assign wb_wdata_o     = r_wb_wdata;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural divider of random latency.
// Expected writebacks are queued at issue time and popped by a monitor.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid_i = 1'b0;
    logic        is_div_i = 1'b0;
    logic [2:0]  funct3_i = 3'b0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        div_start_o;
    logic [2:0]  div_op_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic [4:0]  div_waddr_o;
    logic        div_ready_i;
    logic        div_busy_i;
    logic [31:0] div_result_i;
    logic [4:0]  div_waddr_i;
    logic        hold_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;

    always #5 clk = ~clk;

    div_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid_i   (inst_valid_i),
        .is_div_i       (is_div_i),
        .funct3_i       (funct3_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .rd_addr_i      (rd_addr_i),
        .flush_i        (flush_i),
        .div_start_o    (div_start_o),
        .div_op_o       (div_op_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_waddr_o    (div_waddr_o),
        .div_ready_i    (div_ready_i),
        .div_busy_i     (div_busy_i),
        .div_result_i   (div_result_i),
        .div_waddr_i    (div_waddr_i),
        .hold_o         (hold_o),
        .wb_we_o        (wb_we_o),
        .wb_waddr_o     (wb_waddr_o),
        .wb_wdata_o     (wb_wdata_o)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_launch = 0;
    int n_wb     = 0;
    int n_push   = 0;
    int force_lat = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // reference model of the last completed op (what a result cache would hold)
    bit          cm_valid = 1'b0;
    logic [2:0]  cm_op;
    logic [31:0] cm_a, cm_b;

    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit model_hit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_RESULT_CACHE_EN
        return cm_valid && cm_op == op && cm_a == a && cm_b == b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // behavioural divider: launches on start while idle, aborts if start drops
    logic        dv_busy = 1'b0;
    logic        dv_ready = 1'b0;
    logic [31:0] dv_result = '0;
    logic [4:0]  dv_waddr = '0;
    logic [2:0]  dv_op;
    logic [31:0] dv_a, dv_b;
    logic [4:0]  dv_rd;
    int          dv_cnt;
    logic        sp_ready = 1'b0;
    logic [31:0] sp_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            dv_busy  <= 1'b0;
            dv_ready <= 1'b0;
        end else begin
            dv_ready <= 1'b0;
            if (!dv_busy) begin
                if (div_start_o) begin
                    dv_busy  <= 1'b1;
                    dv_op    <= div_op_o;
                    dv_a     <= div_dividend_o;
                    dv_b     <= div_divisor_o;
                    dv_rd    <= div_waddr_o;
                    dv_cnt   <= (div_divisor_o == 0) ? 0 :
                                (force_lat != 0) ? force_lat : int'($urandom_range(1, 12));
                    n_launch <= n_launch + 1;
                end
            end else if (!div_start_o) begin
                dv_busy <= 1'b0;
            end else if (dv_cnt == 0) begin
                dv_busy   <= 1'b0;
                dv_ready  <= 1'b1;
                dv_result <= ref_div(dv_op, dv_a, dv_b);
                dv_waddr  <= dv_rd;
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end
    end

    assign div_ready_i  = dv_ready | sp_ready;
    assign div_result_i = sp_ready ? sp_result : dv_result;
    assign div_waddr_i  = dv_waddr;
    assign div_busy_i   = dv_busy;

    // monitor: every writeback pulse pops and compares one expectation
    always @(negedge clk) begin
        if (wb_we_o === 1'b1) begin
            n_wb++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_wb: got waddr=%0d wdata=0x%08h, required no write", wb_waddr_o, wb_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_waddr", 32'(wb_waddr_o), 32'(mon_e.a));
                check("wb_wdata", wb_wdata_o, mon_e.d);
            end
        end
    end

    // mode: 0 normal, 1 flush mid-wait, 2 flush in ready cycle, 3 rst mid-wait
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int mode);
        bit hit;
        int l0, bad, wb0;
        bit got_rdy;
        hit = model_hit(op, a, b);
        l0  = n_launch;
        inst_valid_i = 1'b1; is_div_i = 1'b1; funct3_i = op;
        rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        #1;
        check("hold_in_accept", 32'(hold_o), 32'd1);
        check("start_in_accept", 32'(div_start_o), 32'd0);
        if (mode == 0) begin
            exp_q.push_back('{rd, ref_div(op, a, b)});
            n_push++;
        end
        @(negedge clk);
        inst_valid_i = 1'b0; is_div_i = 1'b0;
        rs1_data_i = $urandom(); rs2_data_i = $urandom(); rd_addr_i = 5'($urandom());
        #1;
        if (hit) begin
            check("hold_after_hit", 32'(hold_o), 32'd0);
            check("start_after_hit", 32'(div_start_o), 32'd0);
            check("wb_we_after_hit", 32'(wb_we_o), 32'd1);
            @(negedge clk); #1;
            check("no_launch_on_hit", n_launch, l0);
        end else begin
            check("start_after_accept", 32'(div_start_o), 32'd1);
            bad = 0; got_rdy = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (div_ready_i) begin got_rdy = 1'b1; break; end
                if (mode == 1 && i == 10) break;
                if (mode == 3 && i == 5) break;
                if (hold_o !== 1'b1 || div_start_o !== 1'b1) bad++;
                @(negedge clk); #1;
            end
            check("hold_start_while_waiting", bad, 0);
            if (mode == 0 || mode == 2) check("ready_seen", 32'(got_rdy), 32'd1);
            if (mode == 0) begin
                check("hold_in_ready", 32'(hold_o), 32'd0);
                check("start_in_ready", 32'(div_start_o), 32'd0);
                cm_valid = 1'b1; cm_op = op; cm_a = a; cm_b = b;
                @(negedge clk); #1;
                check("wb_pulse", 32'(wb_we_o), 32'd1);
            end else if (mode == 2) begin
                flush_i = 1'b1; #1;
                check("hold_flush_ready", 32'(hold_o), 32'd0);
                check("start_flush_ready", 32'(div_start_o), 32'd0);
                @(negedge clk); flush_i = 1'b0; #1;
                check("no_wb_flush_ready", 32'(wb_we_o), 32'd0);
            end else if (mode == 1) begin
                flush_i = 1'b1; #1;
                check("start_in_flush", 32'(div_start_o), 32'd0);
                check("hold_in_flush", 32'(hold_o), 32'd0);
                @(negedge clk); flush_i = 1'b0; #1;
                check("start_after_flush", 32'(div_start_o), 32'd0);
                check("divider_idle_after_flush", 32'(div_busy_i), 32'd0);
                wb0 = n_wb;
                repeat (50) @(negedge clk);
                #1;
                check("no_wb_after_flush", n_wb, wb0);
            end else begin
                rst = 1'b1;
                @(negedge clk); #1;
                check("rst_start", 32'(div_start_o), 32'd0);
                check("rst_hold", 32'(hold_o), 32'd0);
                check("rst_wb_we", 32'(wb_we_o), 32'd0);
                check("rst_wb_waddr", 32'(wb_waddr_o), 32'd0);
                check("rst_wb_wdata", wb_wdata_o, 32'd0);
                check("rst_div_op", 32'(div_op_o), 32'd0);
                check("rst_dividend", div_dividend_o, 32'd0);
                check("rst_divisor", div_divisor_o, 32'd0);
                check("rst_div_waddr", 32'(div_waddr_o), 32'd0);
                rst = 1'b0;
                cm_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, wb0;
        logic [2:0]  op, p_op;
        logic [31:0] a, b, p_a, p_b;

        repeat (3) @(negedge clk);
        #1;
        check("reset_start", 32'(div_start_o), 32'd0);
        check("reset_hold", 32'(hold_o), 32'd0);
        check("reset_wb_we", 32'(wb_we_o), 32'd0);
        check("reset_wb_waddr", 32'(wb_waddr_o), 32'd0);
        check("reset_wb_wdata", wb_wdata_o, 32'd0);
        check("reset_dividend", div_dividend_o, 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        do_op(INST_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        do_op(INST_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        do_op(INST_DIVU, 32'd100, 32'd0, 5'd7, 0);
        do_op(INST_REMU, 32'd100, 32'd0, 5'd8, 0);
        do_op(INST_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);

        l0 = n_launch;
        do_op(INST_DIVU, 32'd100, 32'd7, 5'd11, 0);
        do_op(INST_REMU, 32'd100, 32'd7, 5'd12, 0);
        repeat (5) @(negedge clk);
        #1;
        check("back_to_back_launches", n_launch, l0 + 2);

        do_op(INST_DIVU, 32'd100, 32'd7, 5'd13, 0);
        do_op(INST_DIVU, 32'd100, 32'd7, 5'd9, 0);

        // ready pulse while idle must be ignored
        wb0 = n_wb;
        sp_result = 32'h1234_5678; sp_ready = 1'b1;
        @(negedge clk); sp_ready = 1'b0; #1;
        check("idle_ready_no_wb", 32'(wb_we_o), 32'd0);
        @(negedge clk); #1;
        check("idle_ready_wb_count", n_wb, wb0);

        // flush while idle blocks the accept
        inst_valid_i = 1'b1; is_div_i = 1'b1; funct3_i = INST_DIV;
        rs1_data_i = 32'd50; rs2_data_i = 32'd3; rd_addr_i = 5'd4; flush_i = 1'b1;
        #1;
        check("idle_flush_hold", 32'(hold_o), 32'd0);
        @(negedge clk);
        inst_valid_i = 1'b0; is_div_i = 1'b0; flush_i = 1'b0; #1;
        check("idle_flush_no_start", 32'(div_start_o), 32'd0);

        force_lat = 40;
        do_op(INST_DIV, 32'd1000, 32'd3, 5'd14, 1);
        force_lat = 0;
        do_op(INST_DIV, 32'd1000, 32'd3, 5'd15, 0);
        do_op(INST_REM, 32'hFFFF_FF00, 32'd7, 5'd16, 2);
        do_op(INST_REM, 32'hFFFF_FF00, 32'd7, 5'd17, 0);
        force_lat = 40;
        do_op(INST_DIVU, 32'd999, 32'd9, 5'd18, 3);
        force_lat = 0;
        @(negedge clk); #1;
        do_op(INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd19, 0);

        p_op = INST_DIV; p_a = 32'd1; p_b = 32'd1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0 && $urandom_range(0, 7) == 0) begin
                op = p_op; a = p_a; b = p_b;
            end else begin
                op = 3'($urandom_range(4, 7));
                a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom();
                case ($urandom_range(0, 3))
                    0:       b = 32'd0;
                    1:       b = 32'($urandom_range(1, 9));
                    2:       b = 32'hFFFF_FFFF;
                    default: b = $urandom();
                endcase
            end
            do_op(op, a, b, 5'($urandom_range(1, 31)), 0);
            p_op = op; p_a = a; p_b = b;
        end

        repeat (5) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("wb_count", n_wb, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-side issue/writeback controller for the M-extension divide unit.
- Accepts DIV/DIVU/REM/REMU from the ex stage and latches the operands and the destination register.
- Holds the divide request to the divider for the whole operation, stalls the pipeline, and writes the result back to the register file.
- Cancels cleanly on a pipeline flush.

Parameters:
- XLEN, 32, operand/result width
- RADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_valid_i  in  1  ex-stage instruction valid
- is_div_i  in  1  instruction is divide-class (funct7=0000001, funct3[2]=1)
- funct3_i  in  3  divide op
- rs1_data_i  in  XLEN  dividend
- rs2_data_i  in  XLEN  divisor
- rd_addr_i  in  RADDR_W  destination register
- flush_i  in  1  pipeline flush (jump/interrupt)
- div_start_o  out  1  divider request; must stay high for the whole operation
- div_op_o  out  3  op to divider
- div_dividend_o  out  XLEN  latched dividend
- div_divisor_o  out  XLEN  latched divisor
- div_waddr_o  out  RADDR_W  latched rd to divider
- div_ready_i  in  1  one-cycle result-valid pulse from divider
- div_busy_i  in  1  divider busy (status only, not used for control)
- div_result_i  in  XLEN  divider result
- div_waddr_i  in  RADDR_W  rd echoed by divider
- hold_o  out  1  stall request to pipeline control
- wb_we_o  out  1  register write enable, one-cycle pulse
- wb_waddr_o  out  RADDR_W  write address
- wb_wdata_o  out  XLEN  write data

Behaviour:
- States: IDLE, WAIT.
- Reset: state=IDLE. Latched op, operands and rd = 0. wb_we_o=0, wb_waddr_o=0, wb_wdata_o=0. div_start_o=0, hold_o=0.
- accept = IDLE & inst_valid_i & is_div_i & !flush_i.
  - On accept: latch funct3, rs1, rs2, rd; go to WAIT.
  - hold_o=1 combinationally in the accept cycle, so ex keeps the instruction.
- WAIT:
  - div_start_o = !div_ready_i (combinational). It drops in the ready cycle so the idle divider does not re-launch the same op.
  - hold_o = !div_ready_i.
  - The pipeline advances on the edge that ends the ready cycle.
- Ready handling (WAIT & div_ready_i & !flush_i):
  - Next cycle: wb_we_o=1, wb_waddr_o=div_waddr_i, wb_wdata_o=div_result_i (registered).
  - Go to IDLE.
- wb_we_o is high for exactly one cycle per completed op; otherwise 0. Data and address hold their last value.
- Flush handling (flush_i in WAIT, including the ready cycle): div_start_o=0 that cycle (aborts the divider), go to IDLE, no writeback, hold_o=0.
- Flush in IDLE: no accept.
- Latency to the divider: start first asserted in the cycle after accept.
- No assumption on divider latency; the controller waits solely for div_ready_i.
  - Divisor 0 completes early.
  - Overflow (0x80000000 / -1) is handled by the divider.
- div_ready_i while IDLE: ignored, no writeback.
- Back-to-back divides: a new accept is possible in the cycle after the ready cycle.
- rst mid-operation: immediate return to reset values; div_start_o low from the next cycle.

Optional Feature:
- Macro DIV_RESULT_CACHE_EN.
- Enabled:
  - After each writeback, store {op, dividend, divisor, result} with a valid bit (cleared by rst).
  - An accept whose op and operands match a valid entry skips the divider: no div_start_o, wb pulse with the cached result and the new rd on the next cycle.
  - hold_o is high only in the accept cycle.
- Disabled: every op goes through the divider; no cache storage.

Decomposition:
- Shared defines package: INST_DIV=3'b100, INST_DIVU=3'b101, INST_REM=3'b110, INST_REMU=3'b111; RstEnable, DivStart, DivResultReady, ZeroWord.
- Optional sub-module div_result_cache (compare/store), instantiated only under DIV_RESULT_CACHE_EN.
- FSM stays in div_ctrl.

Test Plan (bench instantiates div_ctrl plus the divider):
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5 -> hold_o high until result; single wb_we_o pulse, waddr=5, wdata=0xFFFFFFFD.
- REM -7,2 rd=6 -> wdata=0xFFFFFFFF; DIVU 100,0 -> 0xFFFFFFFF; REMU 100,0 -> 100; DIV 0x80000000,0xFFFFFFFF -> 0x80000000.
- Back-to-back DIVU 100/7 then REMU 100/7 -> two wb pulses: 14 then 2; div_start_o low in each ready cycle; no third launch.
- flush_i pulsed 10 cycles into a DIV -> div_start_o low next, divider busy clears, no wb_we_o, hold_o=0, next accept works normally.
- rst asserted mid-WAIT -> all outputs 0 next cycle; a subsequent DIV completes correctly.
- With DIV_RESULT_CACHE_EN: repeat DIVU 100/7 to rd=9 -> no div_start_o, wb pulse on the cycle after accept with 14, waddr=9.
